// File: rtl/bcd_serial_converter.sv
// Serial binary-to-BCD converter (shift-add-3), one input bit per clock, with a
// start/busy/done handshake and held digit, leading-zero blank and overflow outputs.
module bcd_serial_converter #(
  parameter int IN_WIDTH = 32,
  parameter int DIGITS   = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [IN_WIDTH-1:0]   binary_in,
  input  logic [7:0]            length,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     blank,
  output logic                  overflow
);

  localparam int BW = 4 * DIGITS;

  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

  state_t              r_state, w_state_next;
  logic [IN_WIDTH-1:0] r_shift, w_shift_next;
  logic [BW-1:0]       r_scratch, w_scratch_next, w_adj;
  logic                r_ovf_acc, w_ovf_acc_next;
  logic [7:0]          r_count, w_count_next, w_len;
  logic                r_done;
  logic [BW-1:0]       r_bcd;
  logic [DIGITS-1:0]   r_blank, w_blank;
  logic                r_overflow;

  // Lengths beyond the input width clamp to the full width.
  assign w_len = (length > 8'(IN_WIDTH)) ? 8'(IN_WIDTH) : length;

  always_comb begin
    w_adj = r_scratch;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_scratch[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_scratch[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    logic v_zero;
    w_blank = '0;
    v_zero  = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      v_zero     = v_zero & (r_scratch[4*i +: 4] == 4'd0);
      w_blank[i] = v_zero;
    end
  end

  // NOTE: every signal gets a default before the case so no path can infer a latch.
  always_comb begin
    w_state_next   = r_state;
    w_shift_next   = r_shift;
    w_scratch_next = r_scratch;
    w_ovf_acc_next = r_ovf_acc;
    w_count_next   = r_count;
    case (r_state)
      IDLE: begin
        if (start) begin
          // Left-align so bit L-1 becomes the MSB; bits above it fall off the top.
          w_shift_next   = binary_in << (8'(IN_WIDTH) - w_len);
          w_scratch_next = '0;
          w_ovf_acc_next = 1'b0;
          w_count_next   = w_len;
          w_state_next   = (w_len == 8'd0) ? FINISH : SHIFT;
        end
      end
      SHIFT: begin
        w_scratch_next = {w_adj[BW-2:0], r_shift[IN_WIDTH-1]};
        w_shift_next   = r_shift << 1;
        w_ovf_acc_next = r_ovf_acc | w_adj[BW-1];
        w_count_next   = r_count - 8'd1;
        if (r_count == 8'd1) w_state_next = FINISH;
      end
      FINISH:  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so all flops update from pre-edge values.
  // NOTE: the datapath flops are few and plain registers, so they are all reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_scratch  <= '0;
      r_ovf_acc  <= 1'b0;
      r_count    <= '0;
      r_done     <= 1'b0;
      r_bcd      <= '0;
      r_blank    <= {{(DIGITS-1){1'b1}}, 1'b0};
      r_overflow <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_shift   <= w_shift_next;
      r_scratch <= w_scratch_next;
      r_ovf_acc <= w_ovf_acc_next;
      r_count   <= w_count_next;
      r_done    <= (r_state == FINISH);
      if (r_state == FINISH) begin
        r_bcd      <= r_scratch;
        r_blank    <= w_blank;
        r_overflow <= r_ovf_acc;
      end
    end
  end

  assign busy     = (r_state != IDLE);
  assign done     = r_done;
  assign bcd_out  = r_bcd;
  assign blank    = r_blank;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_bcd_serial_converter.sv
// Directed table-driven bench for bcd_serial_converter plus hand-written sequences
// for start-while-busy, back-to-back start and mid-conversion reset.
module tb_bcd_serial_converter;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] binary_in;
  logic [7:0]  length;
  logic        busy;
  logic        done;
  logic [31:0] bcd_out;
  logic [7:0]  blank;
  logic        overflow;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] prev_bcd = 32'h0;

  typedef struct {
    logic [31:0] bin;
    logic [7:0]  len;
    int          lat;
    logic [31:0] bcd;
    logic [7:0]  blank;
    logic        ovf;
  } vec_t;

  vec_t vecs[8];

  bcd_serial_converter #(.IN_WIDTH(32), .DIGITS(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .binary_in (binary_in),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .bcd_out   (bcd_out),
    .blank     (blank),
    .overflow  (overflow)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    bit both;
    lat  = -1;
    both = 1'b0;
    @(negedge clock);
    start     = 1'b1;
    binary_in = v.bin;
    length    = v.len;
    @(posedge clock); #1;
    start     = 1'b0;
    binary_in = $urandom;
    length    = 8'($urandom_range(0, 255));
    check("busy_at_accept", 32'(busy), 32'd1);
    check("bcd_held_while_busy", bcd_out, prev_bcd);
    for (int k = 1; k <= 100; k++) begin
      @(posedge clock); #1;
      if (busy && done) both = 1'b1;
      if (done) begin
        lat = k;
        break;
      end
    end
    check("latency", 32'(lat), 32'(v.lat));
    check("busy_done_exclusive", 32'(both), 32'd0);
    check("busy_in_done_cycle", 32'(busy), 32'd0);
    check("bcd_out", bcd_out, v.bcd);
    check("blank", 32'(blank), 32'(v.blank));
    check("overflow", 32'(overflow), 32'(v.ovf));
    @(posedge clock); #1;
    check("done_one_cycle", 32'(done), 32'd0);
    check("bcd_hold_after_done", bcd_out, v.bcd);
    prev_bcd = v.bcd;
  endtask

  initial begin
    int dones;
    int first_lat;

    vecs[0] = '{32'd12345678,  8'd24, 25, 32'h12345678, 8'h00, 1'b0};
    vecs[1] = '{32'd42,        8'd8,   9, 32'h00000042, 8'hFC, 1'b0};
    vecs[2] = '{32'h0000FFFF,  8'd0,   1, 32'h00000000, 8'hFE, 1'b0};
    vecs[3] = '{32'd99999999,  8'd27, 28, 32'h99999999, 8'h00, 1'b0};
    vecs[4] = '{32'd100000000, 8'd27, 28, 32'h00000000, 8'hFE, 1'b1};
    vecs[5] = '{32'hFFFFFFFF,  8'd40, 33, 32'h94967295, 8'h00, 1'b1};
    vecs[6] = '{32'hFFFFFF05,  8'd4,   5, 32'h00000005, 8'hFE, 1'b0};
    vecs[7] = '{32'd1000,      8'd16, 17, 32'h00001000, 8'hF0, 1'b0};

    reset     = 1'b1;
    start     = 1'b0;
    binary_in = '0;
    length    = '0;
    repeat (2) @(posedge clock);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_bcd", bcd_out, 32'h0);
    check("reset_blank", 32'(blank), 32'hFE);
    check("reset_overflow", 32'(overflow), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Extra start pulses during a 33-cycle conversion must not spawn another done.
    dones     = 0;
    first_lat = -1;
    @(negedge clock);
    start     = 1'b1;
    binary_in = 32'hFFFFFFFF;
    length    = 8'd40;
    @(posedge clock); #1;
    start = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clock); #1;
      if (done) begin
        dones++;
        if (first_lat < 0) first_lat = k;
      end
      start     = (k == 4 || k == 19) ? 1'b1 : 1'b0;
      binary_in = 32'd3;
      length    = 8'd2;
    end
    check("busy_start_done_count", 32'(dones), 32'd1);
    check("busy_start_latency", 32'(first_lat), 32'd33);
    check("busy_start_bcd", bcd_out, 32'h94967295);
    check("busy_start_overflow", 32'(overflow), 32'd1);

    // Start held during the done cycle is accepted on the very next edge.
    @(negedge clock);
    start     = 1'b1;
    binary_in = 32'd42;
    length    = 8'd8;
    @(posedge clock); #1;
    binary_in = 32'd7;
    length    = 8'd3;
    first_lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clock); #1;
      if (done) begin
        first_lat = k;
        break;
      end
    end
    check("b2b_first_latency", 32'(first_lat), 32'd9);
    check("b2b_first_bcd", bcd_out, 32'h42);
    @(posedge clock); #1;
    start = 1'b0;
    check("b2b_busy_after_accept", 32'(busy), 32'd1);
    check("b2b_done_low", 32'(done), 32'd0);
    first_lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clock); #1;
      if (done) begin
        first_lat = k;
        break;
      end
    end
    check("b2b_second_latency", 32'(first_lat), 32'd4);
    check("b2b_second_bcd", bcd_out, 32'h7);
    check("b2b_second_blank", 32'(blank), 32'hFE);

    // Asynchronous reset ten clocks into a conversion aborts it without a done.
    @(negedge clock);
    start     = 1'b1;
    binary_in = 32'd12345678;
    length    = 8'd24;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_done", 32'(done), 32'd0);
    check("midreset_bcd", bcd_out, 32'h0);
    check("midreset_blank", 32'(blank), 32'hFE);
    check("midreset_overflow", 32'(overflow), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    dones = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clock); #1;
      if (done) dones++;
    end
    check("midreset_no_done", 32'(dones), 32'd0);
    prev_bcd = 32'h0;
    run_vec(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
